// File: rtl/fmul_pkg.sv
// Shared widths and the binary32 field layout for the FPU multiplier.
package fmul_pkg;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;
endpackage

// File: rtl/mant_mul24.sv
// Unsigned 24x24 -> 48 significand multiplier, purely combinational.
module mant_mul24 (
  input  logic [23:0] i_a,
  input  logic [23:0] i_b,
  output logic [47:0] o_p
);
  assign o_p = {24'b0, i_a} * {24'b0, i_b};
endmodule

// File: rtl/fmul_unit.sv
// Binary32 multiplier: single-cycle datapath with RNE rounding, flush-to-zero
// for denormals/underflow, and a registered result plus overflow flag.
module fmul_unit
  import fmul_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  output logic [31:0] y,
  output logic        ovf
);
  fp32_t              w_a;
  fp32_t              w_b;
  logic               w_sign;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_a_spec;
  logic               w_b_spec;
  logic [MAN_W:0]     w_ma;
  logic [MAN_W:0]     w_mb;
  logic [47:0]        w_prod;
  logic               w_norm;
  logic [MAN_W-1:0]   w_mant_pre;
  logic               w_guard;
  logic               w_rs;
  logic               w_round_up;
  logic [MAN_W:0]     w_mant_rnd;
  logic               w_carry;
  logic signed [9:0]  w_exp_fin;
  logic               w_exp_hi;
  logic               w_exp_lo;
  fp32_t              w_res;
  logic               w_res_ovf;

  logic               r_valid;
  logic [31:0]        r_y;
  logic               r_ovf;

  assign w_a      = fp32_t'(x1);
  assign w_b      = fp32_t'(x2);
  assign w_sign   = w_a.sign ^ w_b.sign;
  assign w_a_zero = (w_a.exp == '0);
  assign w_b_zero = (w_b.exp == '0);
  assign w_a_spec = (w_a.exp == EXP_W'(EXP_MAX));
  assign w_b_spec = (w_b.exp == EXP_W'(EXP_MAX));
  assign w_ma     = {1'b1, w_a.man};
  assign w_mb     = {1'b1, w_b.man};

  mant_mul24 u_mant_mul24 (
    .i_a (w_ma),
    .i_b (w_mb),
    .o_p (w_prod)
  );

  // Product lies in [1,4): bit 47 set means the leading one moved up a place.
  assign w_norm     = w_prod[47];
  assign w_mant_pre = w_norm ? w_prod[46:24] : w_prod[45:23];
  assign w_guard    = w_norm ? w_prod[23]    : w_prod[22];
  assign w_rs       = w_norm ? (|w_prod[22:0]) : (|w_prod[21:0]);

  // Round and sticky only matter as an OR once the guard bit is known.
  assign w_round_up = w_guard & (w_rs | w_mant_pre[0]);
  assign w_mant_rnd = {1'b0, w_mant_pre} + (MAN_W+1)'(w_round_up);
  assign w_carry    = w_mant_rnd[MAN_W];

  assign w_exp_fin = 10'(w_a.exp) + 10'(w_b.exp) - 10'(BIAS)
                   + 10'(w_norm) + 10'(w_carry);
  assign w_exp_hi  = (w_exp_fin >= $signed(10'(EXP_MAX)));
  assign w_exp_lo  = (w_exp_fin <= 10'sd0);

  always_comb begin
    w_res.sign = w_sign;
    w_res.exp  = w_exp_fin[EXP_W-1:0];
    w_res.man  = w_mant_rnd[MAN_W-1:0];
    w_res_ovf  = 1'b0;
    if (w_a_zero || w_b_zero) begin
      w_res.exp = '0;
      w_res.man = '0;
    end else if (w_a_spec || w_b_spec) begin
      w_res.exp = '1;
      w_res.man = '0;
    end else if (w_exp_hi) begin
      w_res.exp = '1;
      w_res.man = '0;
      w_res_ovf = 1'b1;
    end else if (w_exp_lo) begin
      w_res.exp = '0;
      w_res.man = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_y   <= w_res;
        r_ovf <= w_res_ovf;
      end
    end
  end

  assign out_valid = r_valid;
  assign y         = r_y;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_fmul_unit.sv
// Self-checking bench for fmul_unit: directed vectors, exponent sweep against
// an integer-arithmetic IEEE RNE model, and an asynchronous reset sequence.
module tb_fmul_unit;
  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic [31:0] y;
  logic        ovf;

  int n_checks;
  int n_errors;

  logic        pend_v;
  logic [31:0] pend_a;
  logic [31:0] pend_b;
  logic [31:0] exp_y;
  logic        exp_ovf;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ry;
    logic        rovf;
  } vec_t;

  vec_t tv[17];

  fmul_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .y         (y),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s (%h * %h): got %h, expected %h", name, pend_a, pend_b, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s (%h * %h): got %0b, expected %0b", name, pend_a, pend_b, act, req);
    end
  endtask

  // Reference: exact integer product, then RNE to 24 significant bits.
  task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ry, output logic rovf);
    logic s;
    int e1, e2, e, sh;
    longint unsigned m1, m2, p, q, rem, half;
    s  = a[31] ^ b[31];
    e1 = int'(a[30:23]);
    e2 = int'(b[30:23]);
    m1 = (64'd1 << 23) | 64'(a[22:0]);
    m2 = (64'd1 << 23) | 64'(b[22:0]);
    p  = m1 * m2;
    rovf = 1'b0;
    if (e1 == 0 || e2 == 0) begin
      ry = {s, 31'b0};
    end else if (e1 == 255 || e2 == 255) begin
      ry = {s, 8'hFF, 23'b0};
    end else begin
      e = e1 + e2 - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e  = e + 1;
      end else begin
        sh = 23;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        ry   = {s, 8'hFF, 23'b0};
        rovf = 1'b1;
      end else if (e <= 0) begin
        ry = {s, 31'b0};
      end else begin
        ry = {s, 8'(e), q[22:0]};
      end
    end
  endtask

  // Check the outputs for the previous cycle's input, then drive this cycle's.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ey, input logic eo, input bit verbose);
    @(negedge clk);
    chk1("out_valid", out_valid, pend_v);
    chk32("y", y, exp_y);
    chk1("ovf", ovf, exp_ovf);
    if (verbose && pend_v)
      $display("txn %h * %h -> y=%h ovf=%0b", pend_a, pend_b, y, ovf);
    in_valid = v;
    x1       = a;
    x2       = b;
    pend_v   = v;
    pend_a   = a;
    pend_b   = b;
    if (v) begin
      exp_y   = ey;
      exp_ovf = eo;
    end
  endtask

  function automatic logic [22:0] pick_man();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       return 23'h000000;
      1:       return 23'h000001;
      2:       return 23'h000002;
      3:       return 23'h380000;
      4:       return 23'h400000;
      5:       return 23'h2FFFFF;
      6:       return 23'h7FFFFF;
      default: return 23'($urandom());
    endcase
  endfunction

  initial begin
    int exps[$];
    logic [31:0] a, b, ry;
    logic        ro, sa, sb;

    clk = 1'b0; rstn = 1'b0; in_valid = 1'b0; x1 = '0; x2 = '0;
    n_checks = 0; n_errors = 0;
    pend_v = 1'b0; pend_a = '0; pend_b = '0; exp_y = '0; exp_ovf = 1'b0;

    tv[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0};
    tv[1]  = '{32'h3FC00000, 32'hC0000000, 32'hC0400000, 1'b0};
    tv[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0};
    tv[3]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0};
    tv[4]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1};
    tv[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0};
    tv[6]  = '{32'hFF000000, 32'h40000000, 32'hFF800000, 1'b1};
    tv[7]  = '{32'h80800000, 32'h00800000, 32'h80000000, 1'b0};
    tv[8]  = '{32'h7F800000, 32'h00000000, 32'h00000000, 1'b0};
    tv[9]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0};
    tv[10] = '{32'h7FC00000, 32'hBF800000, 32'hFF800000, 1'b0};
    tv[11] = '{32'h80000000, 32'h7F800000, 32'h80000000, 1'b0};
    tv[12] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0};
    tv[13] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0};
    tv[14] = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0};
    tv[15] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0};
    tv[16] = '{32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_y", y, 32'h0);
    chk1("rst_ovf", ovf, 1'b0);
    rstn = 1'b1;

    // Directed table, back-to-back
    for (int i = 0; i < 17; i++)
      step(1'b1, tv[i].a, tv[i].b, tv[i].ry, tv[i].rovf, 1'b1);
    step(1'b0, 32'hDEADBEEF, 32'h12345678, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Exponent sweep with random signs, corner/random mantissas, idle gaps
    for (int e = 1; e <= 254; e += 3) exps.push_back(e);
    exps.push_back(254); exps.push_back(2); exps.push_back(126);
    exps.push_back(127); exps.push_back(128);
    for (int i = 0; i < exps.size(); i++) begin
      for (int j = 0; j < exps.size(); j++) begin
        sa = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        a  = {sa, 8'(exps[i]), pick_man()};
        b  = {sb, 8'(exps[j]), pick_man()};
        ref_mul(a, b, ry, ro);
        step(1'b1, a, b, ry, ro, 1'b0);
        if ($urandom_range(0, 15) == 0)
          step(1'b0, $urandom(), $urandom(), 32'h0, 1'b0, 1'b0);
      end
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    $display("sweep done: %0d exponent values per operand", exps.size());

    // Asynchronous reset mid-stream
    step(1'b1, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk1("pre_rst_out_valid", out_valid, 1'b1);
    chk32("pre_rst_y", y, 32'h40000000);
    x1 = 32'h7F000000; x2 = 32'h40000000; in_valid = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk1("async_rst_out_valid", out_valid, 1'b0);
    chk32("async_rst_y", y, 32'h0);
    chk1("async_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    chk1("held_rst_out_valid", out_valid, 1'b0);
    chk32("held_rst_y", y, 32'h0);
    $display("txn async reset mid-stream -> y=%h ovf=%0b out_valid=%0b", y, ovf, out_valid);
    rstn = 1'b1; in_valid = 1'b0;
    pend_v = 1'b0; exp_y = '0; exp_ovf = 1'b0;
    pend_a = 32'h7F000000; pend_b = 32'h40000000;
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h3FC00000, 32'hC0000000, 32'hC0400000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
